// File: rtl/matrix_result_serializer.sv
// Matrix result serializer: captures a parallel result matrix and
// streams its elements row-major over a valid/ready handshake.
module matrix_result_serializer #(
    parameter int C_DATA_WIDTH = 18,
    parameter int A_ROWS       = 8,
    parameter int B_COLUMNS    = 5
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    input  logic [C_DATA_WIDTH-1:0] c_i [0:A_ROWS*B_COLUMNS-1],
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [C_DATA_WIDTH-1:0] m_data_o,
    output logic [((A_ROWS > 1) ? $clog2(A_ROWS) : 1)-1:0] m_row_o,
    output logic [((B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1)-1:0] m_col_o,
    output logic                    m_last_o,
    output logic                    busy_o,
    output logic                    overflow_o
);

    localparam int N  = A_ROWS * B_COLUMNS;
    localparam int RW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
    localparam int CW = (B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(B_COLUMNS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [C_DATA_WIDTH-1:0] buffer_q [0:N-1];
    logic [IW-1:0]           index_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic                    overflow_q;

    logic fire;
    logic at_last;
    logic capture;
    logic drop;

    // A transfer depends only on registered state and ready, never on valid_i.
    assign fire    = (state_q == STREAM) && m_ready_i;
    assign at_last = (index_q == LAST_IDX);
    // Capture from idle, or seamlessly on the final transfer of a matrix.
    assign capture = valid_i && ((state_q == IDLE) || (fire && at_last));
    // Any other strobe while streaming is lost and recorded.
    assign drop    = valid_i && (state_q == STREAM) && !(fire && at_last);

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter on capture, leave after last transfer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (fire && at_last && !valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Matrix buffer load; contents are don't-care until captured
    always_ff @(posedge clk_i) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                buffer_q[i] <= c_i[i];
            end
        end
    end

    // Element index with row/column tracked alongside to avoid a divider
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            index_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (capture) begin
            index_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (fire) begin
            if (at_last) begin
                index_q <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                index_q <= index_q + IW'(1);
                if (col_q == COL_MAX) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Output decode: stream fields are zero whenever no element is offered
    always_comb begin
        m_valid_o  = 1'b0;
        m_data_o   = '0;
        m_row_o    = '0;
        m_col_o    = '0;
        m_last_o   = 1'b0;
        busy_o     = 1'b0;
        overflow_o = overflow_q;
        if (state_q == STREAM) begin
            m_valid_o = 1'b1;
            m_data_o  = buffer_q[index_q];
            m_row_o   = row_q;
            m_col_o   = col_q;
            m_last_o  = at_last;
            busy_o    = 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed testbench for matrix_result_serializer (8x5 matrix, 18-bit data).
// Expected values are hand-derived from the element index.
module tb_matrix_result_serializer;

    localparam int W  = 18;
    localparam int NR = 8;
    localparam int NC = 5;
    localparam int N  = NR * NC;

    logic          clk;
    logic          reset;
    logic          valid;
    logic [W-1:0]  c [0:N-1];
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [2:0]    m_row;
    logic [2:0]    m_col;
    logic          m_last;
    logic          busy;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    matrix_result_serializer #(
        .C_DATA_WIDTH (W),
        .A_ROWS       (NR),
        .B_COLUMNS    (NC)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .valid_i    (valid),
        .c_i        (c),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_data_o   (m_data),
        .m_row_o    (m_row),
        .m_col_o    (m_col),
        .m_last_o   (m_last),
        .busy_o     (busy),
        .overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_elem(input string tag, input int k, input int val);
        chk({tag, " valid"}, 32'(m_valid), 32'd1);
        chk({tag, " data"}, 32'(m_data), 32'(val));
        chk({tag, " row"}, 32'(m_row), 32'(k / NC));
        chk({tag, " col"}, 32'(m_col), 32'(k % NC));
        chk({tag, " last"}, 32'(m_last), 32'(k == N - 1));
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(m_valid), 32'd0);
        chk({tag, " data"}, 32'(m_data), 32'd0);
        chk({tag, " row"}, 32'(m_row), 32'd0);
        chk({tag, " col"}, 32'(m_col), 32'd0);
        chk({tag, " last"}, 32'(m_last), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic load_seq();
        for (int i = 0; i < N; i++) c[i] = W'(i + 1);
    endtask

    task automatic start();
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        int k;
        reset   = 1'b1;
        valid   = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < N; i++) c[i] = '0;

        // Reset: two cycles, all outputs low
        tick();
        tick();
        chk_idle("reset");
        chk("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();
        chk_idle("post-reset idle");

        // Basic stream, ready always high
        load_seq();
        m_ready = 1'b1;
        start();
        for (int i = 0; i < N; i++) begin
            chk_elem("basic", i, i + 1);
            tick();
        end
        chk_idle("basic end");
        chk("basic overflow", 32'(overflow), 32'd0);

        // Backpressure: ready alternates 1,0; data must hold on stalls
        load_seq();
        m_ready = 1'b1;
        start();
        k = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            m_ready = (cyc % 2 == 0);
            if (k < N) chk_elem("bp", k, k + 1);
            tick();
            if (m_ready) k++;
        end
        chk("bp count", 32'(k), 32'(N));
        chk_idle("bp end");

        // Overflow: strobe with new data at element 10 must be dropped
        load_seq();
        m_ready = 1'b1;
        start();
        for (int i = 0; i < N; i++) begin
            chk_elem("ovf", i, i + 1);
            if (i == 9) begin
                chk("ovf before", 32'(overflow), 32'd0);
                valid = 1'b1;
                for (int j = 0; j < N; j++) c[j] = W'(500);
            end
            tick();
            if (i == 9) begin
                valid = 1'b0;
                chk("ovf set", 32'(overflow), 32'd1);
            end
        end
        chk_idle("ovf end");
        chk("ovf sticky", 32'(overflow), 32'd1);
        reset = 1'b1;
        tick();
        chk("ovf cleared", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Back-to-back capture on the final transfer, no bubble
        load_seq();
        m_ready = 1'b1;
        start();
        for (int i = 0; i < N; i++) begin
            chk_elem("b2b first", i, i + 1);
            if (i == N - 1) begin
                for (int j = 0; j < N; j++) c[j] = W'(100 + j);
                valid = 1'b1;
            end
            tick();
            valid = 1'b0;
        end
        chk("b2b overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < N; i++) begin
            chk_elem("b2b second", i, 100 + i);
            tick();
        end
        chk_idle("b2b end");
        chk("b2b end overflow", 32'(overflow), 32'd0);

        // Mid-stream reset at element 20, with a strobe in the same cycle
        load_seq();
        m_ready = 1'b1;
        start();
        for (int i = 0; i < 20; i++) begin
            chk_elem("mid", i, i + 1);
            if (i == 5) valid = 1'b1;
            if (i == 19) begin
                reset = 1'b1;
                valid = 1'b1;
            end
            tick();
            valid = 1'b0;
            if (i == 5) chk("mid ovf set", 32'(overflow), 32'd1);
        end
        chk_idle("mid reset");
        chk("mid reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();
        chk_idle("mid idle");
        for (int j = 0; j < N; j++) c[j] = W'(3 * (j + 1));
        start();
        for (int i = 0; i < N; i++) begin
            chk_elem("restart", i, 3 * (i + 1));
            tick();
        end
        chk_idle("restart end");
        chk("restart overflow", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 18, width of one result element.
REQ-002 SHALL have parameter A_ROWS, default 8, number of result rows.
REQ-003 SHALL have parameter B_COLUMNS, default 5, number of result columns; N = A_ROWS*B_COLUMNS elements.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_i  input  1  capture strobe, driven by the multiplier's valid_o.
REQ-007 SHALL have port c_i  input  C_DATA_WIDTH x [0:N-1]  parallel result matrix, row-major (index = row*B_COLUMNS + col).
REQ-008 SHALL have port m_valid_o  output  1  stream element valid.
REQ-009 SHALL have port m_ready_i  input  1  downstream ready.
REQ-010 SHALL have port m_data_o  output  C_DATA_WIDTH  current element.
REQ-011 SHALL have port m_row_o  output  max(1,$clog2(A_ROWS))  row index of current element.
REQ-012 SHALL have port m_col_o  output  max(1,$clog2(B_COLUMNS))  column index of current element.
REQ-013 SHALL have port m_last_o  output  1  high with final element (index N-1).
REQ-014 SHALL have port busy_o  output  1  high while a matrix is held or streaming.
REQ-015 SHALL have port overflow_o  output  1  sticky flag: capture strobe dropped.

Function
REQ-016 SHALL implement two states: IDLE and STREAM.
REQ-017 In IDLE, valid_i=1 SHALL copy all N elements of c_i into an internal buffer, set index to 0, and enter STREAM next cycle.
REQ-018 Latency: valid_i sampled at edge N SHALL give m_valid_o=1 with element 0 after edge N (first cycle following).
REQ-019 In STREAM, m_valid_o SHALL be 1; m_data_o = buffer[index], m_row_o/m_col_o = index decomposition, m_last_o = (index == N-1).
REQ-020 Transfer SHALL occur only when m_valid_o=1 and m_ready_i=1; index increments by 1 per transfer.
REQ-021 While m_valid_o=1 and m_ready_i=0, m_data_o, m_row_o, m_col_o, m_last_o SHALL hold stable.
REQ-022 m_valid_o SHALL NOT depend combinationally on m_ready_i.
REQ-023 Transfer of element N-1 with valid_i=0 SHALL return to IDLE; m_valid_o=0 next cycle.
REQ-024 Transfer of element N-1 with valid_i=1 in same cycle SHALL capture new c_i, reset index to 0, remain in STREAM (no bubble), no overflow.
REQ-025 valid_i=1 in STREAM on any other cycle SHALL be ignored (buffer and index unchanged) and SHALL set overflow_o=1 from next cycle.
REQ-026 overflow_o SHALL clear only on reset.
REQ-027 busy_o SHALL equal (state == STREAM).
REQ-028 When m_valid_o=0, m_data_o, m_row_o, m_col_o, m_last_o SHALL be 0.
REQ-029 Index SHALL count 0..N-1 and never wrap past N-1 without passing through REQ-023/REQ-024.

Reset
REQ-030 reset_i=1 SHALL force IDLE, index 0, m_valid_o=0, m_data_o=0, m_row_o=0, m_col_o=0, m_last_o=0, busy_o=0, overflow_o=0 after the edge.
REQ-031 Reset SHALL take priority over valid_i and handshake in the same cycle; mid-stream reset abandons the matrix with no further transfers.
REQ-032 Buffer contents need not be reset.

Verification (defaults, N=40)
REQ-033 Reset: assert reset_i 2 cycles -> all outputs 0.
REQ-034 Basic: c_i[k]=k+1, valid_i one cycle, m_ready_i=1 -> 40 consecutive transfers 1..40, row/col (0,0)..(7,4), m_last_o only on 40, busy_o low after.
REQ-035 Backpressure: m_ready_i alternating 1,0 -> 40 transfers in 80 cycles, data held during stalls, order 1..40.
REQ-036 Overflow: valid_i with c_i[k]=500 at element 10 -> overflow_o=1 next cycle, stream continues 11..40 unchanged.
REQ-037 Back-to-back: valid_i with c_i[k]=100+k on the element-40 transfer cycle -> next cycle m_data_o=100, no gap, overflow_o=0.
REQ-038 Mid-stream reset at element 20 -> next cycle m_valid_o=0, busy_o=0, overflow_o=0; fresh valid_i restarts at element 0.
